// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution: opcodes, condition codes, NZCV bit positions.
package branch_pkg;

    localparam logic [5:0] OP_BCC = 6'b110000;
    localparam logic [5:0] OP_BR  = 6'b110001;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check: 4-bit cond against NZCV flags.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;
    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_AL: o_taken = 1'b1;
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = !w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = !w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = !w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = !w_v;
            COND_HI: o_taken = w_c && !w_z;
            COND_LS: o_taken = !w_c || w_z;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = !w_z && (w_n == w_v);
            COND_LE: o_taken = w_z || (w_n != w_v);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch resolution: NZCV holding, registered redirect to fetch,
// fixed wrong-path squash window and taken-branch counter.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 2,
    parameter int FORWARD_FLAGS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic        flag_we,
    input  logic [3:0]  flags_in,
    output logic        b_cond,
    output logic        b_abs,
    output logic [15:0] b_relAddr,
    output logic [31:0] b_absAddr,
    output logic        flush,
    output logic [3:0]  flags_q,
    output logic [31:0] taken_cnt
);

    br_state_e   r_state;
    logic [2:0]  r_fcnt;
    logic        r_b_cond, r_b_abs;
    logic [15:0] r_rel;
    logic [31:0] r_abs;
    logic [3:0]  r_flags;
    logic [31:0] r_taken_cnt;

    logic [5:0] w_opcode;
    logic       w_is_bcc, w_is_br, w_cond_true, w_taken;
    logic [3:0] w_eff_flags;
    logic       w_unused;

    assign w_opcode    = id_instr[31:26];
    assign w_is_bcc    = (w_opcode == OP_BCC);
    assign w_is_br     = (w_opcode == OP_BR);
    assign w_eff_flags = (FORWARD_FLAGS != 0 && flag_we) ? flags_in : r_flags;
    assign w_unused    = &{1'b0, id_instr[21:16], id_rs_data[1:0]};

    cond_eval u_cond_eval (
        .i_cond  (id_instr[25:22]),
        .i_flags (w_eff_flags),
        .o_taken (w_cond_true)
    );

    assign w_taken = (r_state == ST_RUN) && id_valid && (w_is_bcc || w_is_br) && w_cond_true;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_fcnt      <= 3'd0;
            r_b_cond    <= 1'b0;
            r_b_abs     <= 1'b0;
            r_rel       <= 16'h0;
            r_abs       <= 32'h0;
            r_flags     <= 4'h0;
            r_taken_cnt <= 32'h0;
        end else begin
            // Flag writes belong to older instructions, so they land even while squashing.
            if (flag_we) r_flags <= flags_in;
            r_b_cond <= 1'b0;
            r_b_abs  <= 1'b0;
            r_rel    <= 16'h0;
            r_abs    <= 32'h0;
            case (r_state)
                ST_RUN: begin
                    if (w_taken) begin
                        r_b_cond    <= 1'b1;
                        r_b_abs     <= w_is_br;
                        r_rel       <= w_is_br ? 16'h0 : id_instr[15:0];
                        r_abs       <= w_is_br ? {id_rs_data[31:2], 2'b00} : 32'h0;
                        r_taken_cnt <= r_taken_cnt + 32'd1;
                        r_state     <= ST_FLUSH;
                        r_fcnt      <= 3'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt <= 3'd1) begin
                        r_state <= ST_RUN;
                        r_fcnt  <= 3'd0;
                    end else begin
                        r_fcnt <= r_fcnt - 3'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign b_cond    = r_b_cond;
    assign b_abs     = r_b_abs;
    assign b_relAddr = r_rel;
    assign b_absAddr = r_abs;
    assign flush     = (r_state == ST_FLUSH);
    assign flags_q   = r_flags;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; a second instance without flag forwarding
// shares the stimulus for the forwarding comparison.
module tb_branch_resolve;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic        flag_we;
    logic [3:0]  flags_in;

    logic        b_cond, b_abs, flush;
    logic [15:0] b_relAddr;
    logic [31:0] b_absAddr, taken_cnt;
    logic [3:0]  flags_q;

    logic        b_cond0, b_abs0, flush0;
    logic [15:0] b_relAddr0;
    logic [31:0] b_absAddr0, taken_cnt0;
    logic [3:0]  flags_q0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    branch_resolve #(.FLUSH_CYCLES(2), .FORWARD_FLAGS(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .flag_we(flag_we), .flags_in(flags_in),
        .b_cond(b_cond), .b_abs(b_abs), .b_relAddr(b_relAddr), .b_absAddr(b_absAddr),
        .flush(flush), .flags_q(flags_q), .taken_cnt(taken_cnt)
    );

    branch_resolve #(.FLUSH_CYCLES(2), .FORWARD_FLAGS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .flag_we(flag_we), .flags_in(flags_in),
        .b_cond(b_cond0), .b_abs(b_abs0), .b_relAddr(b_relAddr0), .b_absAddr(b_absAddr0),
        .flush(flush0), .flags_q(flags_q0), .taken_cnt(taken_cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] bcc(input logic [3:0] c, input logic [15:0] off);
        return {OP_BCC, c, 6'b0, off};
    endfunction

    function automatic logic [31:0] br(input logic [3:0] c);
        return {OP_BR, c, 22'b0};
    endfunction

    // Hand-derived taken masks (bit i = cond i) for NZCV = 0000, 0100, 1001, 0110.
    logic [3:0]  sweep_flags [4] = '{4'b0000, 4'b0100, 4'b1001, 4'b0110};
    logic [15:0] sweep_mask  [4] = '{16'h2D55, 16'h4D53, 16'h2CB5, 16'h4D4B};

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_rs_data = '0;
        flag_we = 1'b0; flags_in = '0;
        exp_cnt = 0;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            id_valid   = 1'($urandom);
            id_instr   = $urandom;
            id_rs_data = $urandom;
            flag_we    = 1'($urandom);
            flags_in   = 4'($urandom);
            step();
        end
        chk("rst_b_cond", {31'b0, b_cond}, 0);
        chk("rst_b_abs", {31'b0, b_abs}, 0);
        chk("rst_rel", {16'b0, b_relAddr}, 0);
        chk("rst_abs", b_absAddr, 0);
        chk("rst_flush", {31'b0, flush}, 0);
        chk("rst_flags", {28'b0, flags_q}, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_b_cond0", {31'b0, b_cond0}, 0);

        id_valid = 1'b0; flag_we = 1'b0; flags_in = '0; id_instr = '0; id_rs_data = '0;
        rst_n = 1'b1;
        step();

        // First branch after reset.
        id_instr = bcc(COND_AL, 16'h0010); id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        exp_cnt = 1;
        chk("first_b_cond", {31'b0, b_cond}, 1);
        chk("first_b_abs", {31'b0, b_abs}, 0);
        chk("first_rel", {16'b0, b_relAddr}, 32'h10);
        chk("first_abs", b_absAddr, 0);
        chk("first_cnt", taken_cnt, 1);
        chk("first_flush", {31'b0, flush}, 1);
        step();
        chk("first_b_cond_pulse", {31'b0, b_cond}, 0);
        chk("first_rel_clr", {16'b0, b_relAddr}, 0);
        step();
        chk("first_flush_end", {31'b0, flush}, 0);

        // Condition sweep.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 16; c++) begin
                flag_we = 1'b1; flags_in = sweep_flags[p]; id_valid = 1'b0;
                step();
                flag_we = 1'b0;
                id_instr = bcc(4'(c), 16'h0100 + 16'(c)); id_valid = 1'b1;
                step();
                id_valid = 1'b0;
                exp_cnt = exp_cnt + {31'b0, sweep_mask[p][c]};
                chk($sformatf("sweep_f%0d_c%0d", p, c), {31'b0, b_cond}, {31'b0, sweep_mask[p][c]});
                chk($sformatf("sweep_rel_f%0d_c%0d", p, c), {16'b0, b_relAddr},
                    sweep_mask[p][c] ? 32'h0100 + 32'(c) : 32'h0);
                chk($sformatf("sweep_cnt_f%0d_c%0d", p, c), taken_cnt, exp_cnt);
                step();
                step();
            end
        end

        // Absolute branch, then a branch offered during the squash window.
        id_instr = br(COND_AL); id_rs_data = 32'h0000_1237; id_valid = 1'b1;
        step();
        exp_cnt = exp_cnt + 1;
        chk("br_b_cond", {31'b0, b_cond}, 1);
        chk("br_b_abs", {31'b0, b_abs}, 1);
        chk("br_abs", b_absAddr, 32'h0000_1234);
        chk("br_rel", {16'b0, b_relAddr}, 0);
        chk("br_flush1", {31'b0, flush}, 1);
        chk("br_cnt", taken_cnt, exp_cnt);
        id_instr = bcc(COND_AL, 16'h0055);
        step();
        chk("shadow1_b_cond", {31'b0, b_cond}, 0);
        chk("shadow1_flush", {31'b0, flush}, 1);
        chk("shadow1_cnt", taken_cnt, exp_cnt);
        step();
        id_valid = 1'b0;
        chk("shadow2_b_cond", {31'b0, b_cond}, 0);
        chk("shadow2_flush", {31'b0, flush}, 0);
        chk("shadow2_cnt", taken_cnt, exp_cnt);

        // Same-cycle flag write with BCC EQ.
        flag_we = 1'b1; flags_in = 4'b0000;
        step();
        flags_in = 4'b0100; id_instr = bcc(COND_EQ, 16'h0022); id_valid = 1'b1;
        step();
        flag_we = 1'b0; id_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        chk("fwd1_b_cond", {31'b0, b_cond}, 1);
        chk("fwd1_rel", {16'b0, b_relAddr}, 32'h22);
        chk("fwd0_b_cond", {31'b0, b_cond0}, 0);
        chk("fwd1_flags", {28'b0, flags_q}, 32'h4);
        chk("fwd0_flags", {28'b0, flags_q0}, 32'h4);
        step();
        step();

        // Reset during the first squash cycle.
        id_instr = bcc(COND_AL, 16'h0033); id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        chk("mid_pre_flush", {31'b0, flush}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_flush", {31'b0, flush}, 0);
        chk("mid_b_cond", {31'b0, b_cond}, 0);
        chk("mid_rel", {16'b0, b_relAddr}, 0);
        chk("mid_cnt", taken_cnt, 0);
        chk("mid_flags", {28'b0, flags_q}, 0);
        step();
        rst_n = 1'b1;
        step();
        id_instr = bcc(COND_NE, 16'h0044); id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        chk("post_b_cond", {31'b0, b_cond}, 1);
        chk("post_rel", {16'b0, b_relAddr}, 32'h44);
        chk("post_cnt", taken_cnt, 1);
        step();
        step();

        // Counter wrap.
        force dut.r_taken_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_taken_cnt;
        chk("wrap_pre", taken_cnt, 32'hFFFF_FFFF);
        id_instr = bcc(COND_AL, 16'h0001); id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        chk("wrap_b_cond", {31'b0, b_cond}, 1);
        chk("wrap_cnt", taken_cnt, 0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
